// File: rtl/cflog_drain.sv
// cflog_drain -- hardware reader for the control-flow log memory.
//
// On an accepted start it walks the log from word 0 up to a latched word
// count. Each {src, dest} pair is fetched through a synchronous read port
// with one cycle of latency and handed to the attestation report path over a
// valid/ready interface.
//
// Ports:
//   mclk, puc_rst          clock, asynchronous active-high reset
//   start, log_count       drain request and number of valid log words
//   rd_en, rd_addr,        log read strobe/address; rd_data is valid the
//   rd_data                cycle after rd_en
//   out_data, out_valid,   {src, dest} pair stream to the report path
//   out_ready
//   busy, done, err        status: not idle, one-cycle completion pulse,
//                          sticky bad-count flag for the last request
//   pairs_sent             pairs handed off since the last accepted start
module cflog_drain #(
  parameter logic [15:0] CFLOW_LOGS_SIZE = 16'h400,
  parameter int          ADDR_MSB        = 10
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              start,
  input  logic [15:0]       log_count,
  output logic              rd_en,
  output logic [ADDR_MSB:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       pairs_sent
);

  localparam int AW = ADDR_MSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_SRC,
    S_FETCH_DEST,
    S_LATCH_DEST,
    S_SEND,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] ptr_q;
  logic [15:0] src_q;
  logic [15:0] dest_q;
  logic        rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] pairs_q;

  // A log holds whole pairs and never exceeds the physical depth; anything
  // else is rejected before a single read is issued.
  logic        bad_cnt_d;
  logic [15:0] ptr_inc_d;
  logic        last_pair_d;
  logic        handshake_d;

  assign bad_cnt_d   = log_count[0] | (log_count > CFLOW_LOGS_SIZE);
  assign ptr_inc_d   = ptr_q + 16'd2;
  assign last_pair_d = (ptr_inc_d == cnt_q);
  assign handshake_d = out_valid_q & out_ready;

  // All outputs come straight from registers, so out_valid never depends
  // combinationally on out_ready.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      src_q       <= '0;
      dest_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pairs_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= log_count;
            ptr_q   <= '0;
            pairs_q <= '0;
            busy_q  <= 1'b1;
            if (bad_cnt_d) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (log_count == 16'd0) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q     <= 1'b0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
              state_q   <= S_FETCH_SRC;
            end
          end
        end

        // Read of the src word is in flight; issue the dest read behind it.
        S_FETCH_SRC: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= AW'(ptr_q + 16'd1);
          state_q   <= S_FETCH_DEST;
        end

        // src word arrives now; dest word arrives next cycle.
        S_FETCH_DEST: begin
          src_q   <= rd_data;
          rd_en_q <= 1'b0;
          state_q <= S_LATCH_DEST;
        end

        S_LATCH_DEST: begin
          dest_q      <= rd_data;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end

        // Pair is held in src_q/dest_q until the sink takes it.
        S_SEND: begin
          if (handshake_d) begin
            out_valid_q <= 1'b0;
            ptr_q       <= ptr_inc_d;
            pairs_q     <= pairs_q + 16'd1;
            if (last_pair_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= AW'(ptr_inc_d);
              state_q   <= S_FETCH_SRC;
            end
          end
        end

        // err is deliberately left alone here: it stays visible in IDLE.
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign out_data   = {src_q, dest_q};
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pairs_sent = pairs_q;

endmodule

// File: tb/tb_cflog_drain.sv
// Directed testbench for cflog_drain: one task per scenario, inline checks.
module tb_cflog_drain;

  localparam int ADDR_MSB = 10;

  logic              mclk = 1'b0;
  logic              puc_rst;
  logic              start;
  logic [15:0]       log_count;
  logic              rd_en;
  logic [ADDR_MSB:0] rd_addr;
  logic [15:0]       rd_data = 16'h0;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       pairs_sent;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:2047];

  cflog_drain #(.CFLOW_LOGS_SIZE(16'h400), .ADDR_MSB(ADDR_MSB)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .log_count(log_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .pairs_sent(pairs_sent)
  );

  always #5 mclk = ~mclk;

  // Synchronous one-cycle-latency log memory.
  always @(posedge mclk) if (rd_en) rd_data <= mem[rd_addr];

  initial for (int i = 0; i < 2048; i++) mem[i] = 16'hE000 + 16'(i << 4);

  task automatic step();
    @(posedge mclk); #1;
  endtask

  // Called in cycle 0; returns in cycle 1 with start dropped and log_count scrambled.
  task automatic kick(input logic [15:0] cnt);
    start = 1'b1; log_count = cnt;
    step();
    start = 1'b0; log_count = 16'hDEAD;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset.rd_en got %b exp 0", rd_en); end
    tests++; if (rd_addr !== '0) begin fails++; $display("FAIL reset.rd_addr got %h exp 0", rd_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset.out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset.out_data got %h exp 0", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset.busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset.done got %b exp 0", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset.err got %b exp 0", err); end
    tests++; if (pairs_sent !== 16'h0) begin fails++; $display("FAIL reset.pairs_sent got %h exp 0", pairs_sent); end
    step();
    puc_rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic e_rd, e_v, e_done, e_busy;
    logic [ADDR_MSB:0] e_addr;
    logic [31:0] e_data;
    out_ready = 1'b1;
    kick(16'd4);
    for (int c = 1; c <= 11; c++) begin
      e_rd   = (c == 1 || c == 2 || c == 5 || c == 6);
      e_addr = (c < 5) ? 11'(c - 1) : 11'(c - 3);
      e_v    = (c == 4 || c == 8);
      e_data = (c == 4) ? 32'hE000E010 : 32'hE020E030;
      e_done = (c == 9);
      e_busy = (c <= 9);
      tests++; if (rd_en !== e_rd) begin fails++; $display("FAIL basic.rd_en c=%0d got %b exp %b", c, rd_en, e_rd); end
      if (e_rd) begin
        tests++; if (rd_addr !== e_addr) begin fails++; $display("FAIL basic.rd_addr c=%0d got %h exp %h", c, rd_addr, e_addr); end
      end
      tests++; if (out_valid !== e_v) begin fails++; $display("FAIL basic.out_valid c=%0d got %b exp %b", c, out_valid, e_v); end
      if (e_v) begin
        tests++; if (out_data !== e_data) begin fails++; $display("FAIL basic.out_data c=%0d got %h exp %h", c, out_data, e_data); end
      end
      tests++; if (done !== e_done) begin fails++; $display("FAIL basic.done c=%0d got %b exp %b", c, done, e_done); end
      tests++; if (busy !== e_busy) begin fails++; $display("FAIL basic.busy c=%0d got %b exp %b", c, busy, e_busy); end
      step();
    end
    tests++; if (pairs_sent !== 16'd2) begin fails++; $display("FAIL basic.pairs_sent got %0d exp 2", pairs_sent); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic.err got %b exp 0", err); end
  endtask

  task automatic test_stall();
    logic e_rd, e_v, e_done, e_busy;
    logic [ADDR_MSB:0] e_addr;
    logic [31:0] e_data;
    out_ready = 1'b1;
    kick(16'd4);
    tests++; if (pairs_sent !== 16'd0) begin fails++; $display("FAIL stall.pairs_clear got %0d exp 0", pairs_sent); end
    for (int c = 1; c <= 16; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      e_rd   = (c == 1 || c == 2 || c == 10 || c == 11);
      e_addr = (c <= 2) ? 11'(c - 1) : 11'(c - 8);
      e_v    = (c >= 4 && c <= 9) || (c == 13);
      e_data = (c <= 9) ? 32'hE000E010 : 32'hE020E030;
      e_done = (c == 14);
      e_busy = (c <= 14);
      tests++; if (rd_en !== e_rd) begin fails++; $display("FAIL stall.rd_en c=%0d got %b exp %b", c, rd_en, e_rd); end
      if (e_rd) begin
        tests++; if (rd_addr !== e_addr) begin fails++; $display("FAIL stall.rd_addr c=%0d got %h exp %h", c, rd_addr, e_addr); end
      end
      tests++; if (out_valid !== e_v) begin fails++; $display("FAIL stall.out_valid c=%0d got %b exp %b", c, out_valid, e_v); end
      if (e_v) begin
        tests++; if (out_data !== e_data) begin fails++; $display("FAIL stall.out_data c=%0d got %h exp %h", c, out_data, e_data); end
      end
      tests++; if (done !== e_done) begin fails++; $display("FAIL stall.done c=%0d got %b exp %b", c, done, e_done); end
      tests++; if (busy !== e_busy) begin fails++; $display("FAIL stall.busy c=%0d got %b exp %b", c, busy, e_busy); end
      step();
    end
    out_ready = 1'b1;
    tests++; if (pairs_sent !== 16'd2) begin fails++; $display("FAIL stall.pairs_sent got %0d exp 2", pairs_sent); end
  endtask

  task automatic test_empty();
    kick(16'd0);
    for (int c = 1; c <= 3; c++) begin
      tests++; if (done !== (c == 1)) begin fails++; $display("FAIL empty.done c=%0d got %b", c, done); end
      tests++; if (busy !== (c == 1)) begin fails++; $display("FAIL empty.busy c=%0d got %b", c, busy); end
      tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL empty.rd_en c=%0d got %b exp 0", c, rd_en); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty.out_valid c=%0d got %b exp 0", c, out_valid); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL empty.err c=%0d got %b exp 0", c, err); end
      step();
    end
  endtask

  task automatic test_bad();
    logic [15:0] bad [2];
    bad[0] = 16'd5;
    bad[1] = 16'h0402;
    for (int k = 0; k < 2; k++) begin
      kick(bad[k]);
      for (int c = 1; c <= 3; c++) begin
        tests++; if (done !== (c == 1)) begin fails++; $display("FAIL bad%0d.done c=%0d got %b", k, c, done); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad%0d.err c=%0d got %b exp 1", k, c, err); end
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL bad%0d.rd_en c=%0d got %b exp 0", k, c, rd_en); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bad%0d.out_valid c=%0d got %b exp 0", k, c, out_valid); end
        step();
      end
    end
    kick(16'd2);
    for (int c = 1; c <= 6; c++) begin
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL bad.clear_err c=%0d got %b exp 0", c, err); end
      tests++; if (done !== (c == 5)) begin fails++; $display("FAIL bad.legal_done c=%0d got %b", c, done); end
      if (c == 4) begin
        tests++; if (out_data !== 32'hE000E010 || out_valid !== 1'b1) begin fails++; $display("FAIL bad.legal_pair got %h/%b exp E000E010/1", out_data, out_valid); end
      end
      step();
    end
  endtask

  task automatic test_full();
    int done_cyc = -1;
    int nvalid = 0;
    logic [31:0] last = '0;
    logic [ADDR_MSB:0] max_addr = '0, prev_a = '0, last_a = '0;
    out_ready = 1'b1;
    kick(16'h0400);
    for (int c = 1; c <= 2200; c++) begin
      if (rd_en) begin
        prev_a = last_a; last_a = rd_addr;
        if (rd_addr > max_addr) max_addr = rd_addr;
      end
      if (out_valid) begin nvalid++; last = out_data; end
      if (done) begin done_cyc = c; break; end
      step();
    end
    tests++; if (done_cyc != 2049) begin fails++; $display("FAIL full.done_cycle got %0d exp 2049", done_cyc); end
    tests++; if (nvalid != 512) begin fails++; $display("FAIL full.pairs_seen got %0d exp 512", nvalid); end
    tests++; if (pairs_sent !== 16'h0200) begin fails++; $display("FAIL full.pairs_sent got %h exp 0200", pairs_sent); end
    tests++; if (last !== 32'h1FE01FF0) begin fails++; $display("FAIL full.last_pair got %h exp 1FE01FF0", last); end
    tests++; if (prev_a !== 11'h3FE || last_a !== 11'h3FF) begin fails++; $display("FAIL full.last_addrs got %h,%h exp 3FE,3FF", prev_a, last_a); end
    tests++; if (max_addr !== 11'h3FF) begin fails++; $display("FAIL full.max_addr got %h exp 3FF", max_addr); end
    step();
    step();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    kick(16'd4);
    for (int c = 1; c < 8; c++) step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL abort.second_send got %b exp 1", out_valid); end
    puc_rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort.out_valid got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort.busy got %b exp 0", busy); end
    tests++; if (pairs_sent !== 16'h0) begin fails++; $display("FAIL abort.pairs_sent got %h exp 0", pairs_sent); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL abort.out_data got %h exp 0", out_data); end
    tests++; if (rd_en !== 1'b0 || rd_addr !== '0) begin fails++; $display("FAIL abort.rd got %b/%h exp 0/0", rd_en, rd_addr); end
    step();
    puc_rst = 1'b0;
    step();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort.idle got done=%b busy=%b exp 0/0", done, busy); end
    kick(16'd4);
    for (int c = 1; c <= 11; c++) begin
      if (c == 2) begin start = 1'b1; log_count = 16'd0; end
      if (c == 3) begin start = 1'b0; log_count = 16'hDEAD; end
      tests++; if (done !== (c == 9)) begin fails++; $display("FAIL abort.done c=%0d got %b", c, done); end
      tests++; if (busy !== (c <= 9)) begin fails++; $display("FAIL abort.busy c=%0d got %b", c, busy); end
      tests++; if (out_valid !== (c == 4 || c == 8)) begin fails++; $display("FAIL abort.out_valid c=%0d got %b", c, out_valid); end
      step();
    end
    tests++; if (pairs_sent !== 16'd2) begin fails++; $display("FAIL abort.pairs_sent got %0d exp 2", pairs_sent); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL abort.err got %b exp 0", err); end
  endtask

  initial begin
    puc_rst = 1'b1; start = 1'b0; log_count = 16'h0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_bad();
    test_full();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
